// File: rtl/dot_seq.sv
// Dot product of two C-element float vectors using one shared external multiplier and adder.
// Each unit gets a one-cycle start, then the sequencer waits for its done; a unit that never answers ends the operation with err.
module dot_seq #(
  parameter int S   = 32,
  parameter int C   = 4,
  parameter int TMO = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [S*C-1:0] a,
  input  logic [S*C-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [S-1:0]   o,
  output logic           nan,
  output logic           overflow,
  output logic           underflow,
  output logic           err,
  output logic           mul_start,
  output logic [S-1:0]   mul_op1,
  output logic [S-1:0]   mul_op2,
  input  logic [S-1:0]   mul_out,
  input  logic           mul_done,
  input  logic           mul_nan,
  input  logic           mul_ovf,
  input  logic           mul_unf,
  output logic           add_start,
  output logic [S-1:0]   add_op1,
  output logic [S-1:0]   add_op2,
  input  logic [S-1:0]   add_out,
  input  logic           add_done,
  input  logic           add_nan,
  input  logic           add_ovf,
  input  logic           add_unf
);

  localparam int KW = (C > 1) ? $clog2(C) : 1;
  localparam int TW = (TMO > 1) ? $clog2(TMO + 1) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_REQ  = 3'd1,
    MUL_WAIT = 3'd2,
    ADD_REQ  = 3'd3,
    ADD_WAIT = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t         state;
  logic [S*C-1:0] a_r;
  logic [S*C-1:0] b_r;
  logic [S-1:0]   acc;
  logic [S-1:0]   prod;
  logic [KW-1:0]  k;
  logic [TW-1:0]  tmo_cnt;

  logic [KW-1:0]  k_nxt;
  logic           last;
  logic           tmo_hit;

  assign k_nxt   = k + KW'(1);
  assign last    = (k == KW'(C - 1));
  assign tmo_hit = (tmo_cnt == TW'(TMO - 1));

  // Element 0 sits in the most-significant slot.
  function automatic logic [S-1:0] elem(input logic [S*C-1:0] v, input logic [KW-1:0] i);
    return v[S*(C-1-int'(i)) +: S];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      nan       <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      mul_start <= 1'b0;
      add_start <= 1'b0;
      o         <= '0;
      acc       <= '0;
      prod      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      mul_op1   <= '0;
      mul_op2   <= '0;
      add_op1   <= '0;
      add_op2   <= '0;
      k         <= '0;
      tmo_cnt   <= '0;
    end else begin
      done      <= 1'b0;
      mul_start <= 1'b0;
      add_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r       <= a;
            b_r       <= b;
            acc       <= '0;
            nan       <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            err       <= 1'b0;
            k         <= '0;
            busy      <= 1'b1;
            mul_start <= 1'b1;
            mul_op1   <= elem(a, '0);
            mul_op2   <= elem(b, '0);
            state     <= MUL_REQ;
          end
        end
        MUL_REQ: begin
          tmo_cnt <= '0;
          state   <= MUL_WAIT;
        end
        MUL_WAIT: begin
          if (mul_done) begin
            prod      <= mul_out;
            nan       <= nan | mul_nan;
            overflow  <= overflow | mul_ovf;
            underflow <= underflow | mul_unf;
            if (k == '0) begin
              // First product seeds the accumulator; no add needed.
              acc <= mul_out;
              if (last) begin
                o     <= mul_out;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                k         <= k_nxt;
                mul_start <= 1'b1;
                mul_op1   <= elem(a_r, k_nxt);
                mul_op2   <= elem(b_r, k_nxt);
                state     <= MUL_REQ;
              end
            end else begin
              add_start <= 1'b1;
              add_op1   <= acc;
              add_op2   <= mul_out;
              state     <= ADD_REQ;
            end
          end else if (tmo_hit) begin
            err   <= 1'b1;
            o     <= acc;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ADD_REQ: begin
          tmo_cnt <= '0;
          state   <= ADD_WAIT;
        end
        ADD_WAIT: begin
          if (add_done) begin
            acc       <= add_out;
            nan       <= nan | add_nan;
            overflow  <= overflow | add_ovf;
            underflow <= underflow | add_unf;
            if (last) begin
              o     <= add_out;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              k         <= k_nxt;
              mul_start <= 1'b1;
              mul_op1   <= elem(a_r, k_nxt);
              mul_op2   <= elem(b_r, k_nxt);
              state     <= MUL_REQ;
            end
          end else if (tmo_hit) begin
            err   <= 1'b1;
            o     <= acc;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dot_seq.md
Name: dot_seq

Overview:
- Initiator side of the float-unit start/done protocol: sequences one external multiplier and one external adder to compute the dot product of two C-element float vectors.
- Issues one-cycle start requests, waits for each unit's done, latches results and accumulates serially.
- Sits between the matrix engine's control and a shared float multiplier/adder pair, replacing per-element unit replication.

Parameters:
S, 32, float width in bits
C, 4, vector length (>=1)
TMO, 255, max cycles to wait for a unit's done before aborting

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  request new dot product; accepted only in IDLE
a  in  S*C  vector A; element 0 in most-significant S bits
b  in  S*C  vector B; same packing
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: result valid
o  out  S  dot-product result; held until next accepted start
nan  out  1  sticky OR of unit nan flags for current operation
overflow  out  1  sticky OR of unit overflow flags
underflow  out  1  sticky OR of unit underflow flags
err  out  1  set with done when a unit timed out
mul_start  out  1  one-cycle request to multiplier
mul_op1  out  S  multiplier operand 1
mul_op2  out  S  multiplier operand 2
mul_out  in  S  multiplier result
mul_done  in  1  multiplier completion
mul_nan, mul_ovf, mul_unf  in  1 each  multiplier flags, valid with mul_done
add_start  out  1  one-cycle request to adder (add only, never subtract)
add_op1  out  S  adder operand 1 (accumulator)
add_op2  out  S  adder operand 2 (latched product)
add_out  in  S  adder result
add_done  in  1  adder completion
add_nan, add_ovf, add_unf  in  1 each  adder flags, valid with add_done

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, err, mul_start, add_start, nan, overflow, underflow = 0; o, acc, prod, operands = 0; index k = 0; timeout counter = 0.
- IDLE: start=1 latches a, b into internal registers, clears sticky flags and err, k=0 → MUL_REQ. start ignored in all other states (no queueing).
- MUL_REQ (1 cycle): mul_start=1, mul_op1/op2 = element k of latched a/b → MUL_WAIT.
- MUL_WAIT: mul_done ignored during the REQ cycle; first cycle here with mul_done=1: prod <= mul_out, OR flags in. If k==0: acc <= mul_out, then k==C-1 ? DONE : (k++, MUL_REQ). Else → ADD_REQ.
- ADD_REQ (1 cycle): add_start=1, add_op1=acc, add_op2=prod → ADD_WAIT.
- ADD_WAIT: first cycle with add_done=1: acc <= add_out, OR flags in; k==C-1 ? DONE : (k++, MUL_REQ).
- DONE (1 cycle): done=1, o <= acc → IDLE. busy=0 from next cycle; start may be accepted in the cycle after done.
- Operands held stable on mul_op*/add_op* from REQ through end of matching WAIT.
- Timeout: counter resets on entry to each WAIT, increments each WAIT cycle; on reaching TMO without done: err=1, o <= acc (partial), → DONE.
- Latency (start-accept edge = cycle 0, unit latency Lm/La counted from start-sampled cycle): done high in cycle 1 + C*(Lm+1) + (C-1)*(La+1).
- C=1: no add issued; o = a0*b0.
- Flags never abort: nan/overflow/underflow propagate to done alongside a valid (possibly special) o.
- rst mid-operation: immediate return to IDLE, no done pulse, request strobes drop same cycle.

Test Plan:
- C=1, Lm=3, a=0x40a00000 (5.0), b=0x40a00000 -> done in cycle 5, o=0x41c80000 (25.0), no add_start ever, flags 0.
- C=4, Lm=3, La=4, a=[1,2,3,4], b=[1,1,1,1] -> exactly 4 mul_start, 3 add_start pulses, done in cycle 32, o=0x41200000 (10.0).
- start pulsed again in cycle 10 of a busy op -> ignored; o and done timing unchanged from previous case.
- Multiplier model asserts mul_ovf on element 2 -> overflow=1 at done; cleared to 0 after next start accepted.
- Adder model never asserts add_done, TMO=8 -> err=1 with done, o = first product, busy drops next cycle.
- rst asserted in cycle 12 of C=4 op -> busy, mul_start, add_start 0 immediately, no done; fresh start then completes normally with correct o.
